// File: rtl/img_stream_tx_if.sv
// AXI-Stream channel carrying booleanized image beats from img_stream_tx to its consumer.
interface img_stream_tx_if;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tlast;

  modport master (output m_tdata, m_tvalid, m_tkeep, m_tlast, input m_tready);
  modport slave  (input m_tdata, m_tvalid, m_tkeep, m_tlast, output m_tready);
endinterface

// File: rtl/img_stream_tx.sv
// Frame-buffered image transmitter: holds one booleanized HEIGHT x WIDTH frame
// and streams it as 128-bit AXI-Stream beats on request.
module img_stream_tx #(
  parameter  int unsigned HEIGHT = 28,
  parameter  int unsigned WIDTH  = 28,
  parameter  int unsigned DATA_W = 128,
  localparam int unsigned NPIX   = HEIGHT * WIDTH,
  localparam int unsigned NBEATS = (NPIX + DATA_W - 1) / DATA_W,
  localparam int unsigned AW     = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              start_i,
  input  logic              abort_i,
  img_stream_tx_if.master   m_axis,
  output logic              busy_o,
  output logic              done_o,
  output logic              wr_err_o,
  output logic [15:0]       frame_count_o
);

  localparam int unsigned KEEP_W    = DATA_W / 8;
  localparam int unsigned REM       = NPIX - (NBEATS - 1) * DATA_W;
  localparam int unsigned REM_BYTES = (REM + 7) / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic [DATA_W-1:0] low_ones_data(input int unsigned n);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_W; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [KEEP_W-1:0] low_ones_keep(input int unsigned n);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) if (i < n) m[i] = 1'b1;
    return m;
  endfunction

  // Padding pixels past the end of the image are forced to 0 on the final beat.
  localparam logic [DATA_W-1:0] LAST_MASK = low_ones_data(REM);
  localparam logic [KEEP_W-1:0] LAST_KEEP = low_ones_keep(REM_BYTES);

  logic [DATA_W-1:0] mem_q [NBEATS];

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     beat_q, beat_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [KEEP_W-1:0] tkeep_q, tkeep_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;
  logic [15:0]       fcount_q, fcount_d;

  logic              wr_ok_c;
  logic [AW-1:0]     beat_nxt;
  logic              nxt_last;
  logic [DATA_W-1:0] word0;

  assign wr_ok_c = wr_en_i && (state_q == ST_IDLE) && (32'(wr_addr_i) < NBEATS);

  // Buffer is deliberately not reset so a frame survives rst.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_c) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      beat_q   <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      fcount_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      fcount_q <= fcount_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_err_d = wr_err_q;
    fcount_d = fcount_q;
    beat_nxt = AW'(beat_q + 1'b1);
    nxt_last = (32'(beat_nxt) == NBEATS - 1);
    // A same-cycle write to word 0 must appear in the first beat.
    word0    = (wr_ok_c && (wr_addr_i == '0)) ? wr_data_i : mem_q[0];

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_SEND;
          beat_d   = '0;
          tvalid_d = 1'b1;
          busy_d   = 1'b1;
          wr_err_d = 1'b0;
          tlast_d  = (NBEATS == 1);
          tdata_d  = word0 & ((NBEATS == 1) ? LAST_MASK : {DATA_W{1'b1}});
          tkeep_d  = (NBEATS == 1) ? LAST_KEEP : {KEEP_W{1'b1}};
        end
      end
      ST_SEND: begin
        if (abort_i) begin
          state_d  = ST_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
        end else if (tvalid_q && m_axis.m_tready) begin
          if (tlast_q) begin
            state_d  = ST_FIN;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            fcount_d = fcount_q + 16'd1;
          end else begin
            beat_d  = beat_nxt;
            tlast_d = nxt_last;
            tdata_d = mem_q[beat_nxt] & (nxt_last ? LAST_MASK : {DATA_W{1'b1}});
            tkeep_d = nxt_last ? LAST_KEEP : {KEEP_W{1'b1}};
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Dropped writes win over the clear from an accepted start.
    if (wr_en_i && !wr_ok_c) wr_err_d = 1'b1;
  end

  assign m_axis.m_tdata  = tdata_q;
  assign m_axis.m_tkeep  = tkeep_q;
  assign m_axis.m_tvalid = tvalid_q;
  assign m_axis.m_tlast  = tlast_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign wr_err_o        = wr_err_q;
  assign frame_count_o   = fcount_q;

endmodule

// File: doc/img_stream_tx.md
IMG_STREAM_TX -- requirements
Module: img_stream_tx

Interface
REQ-001 SHALL have parameter HEIGHT, default 28, image rows.
REQ-002 SHALL have parameter WIDTH, default 28, image columns; one bit per pixel (booleanized).
REQ-003 SHALL have parameter DATA_W, fixed at 128, stream beat width in bits; NBEATS = ceil(HEIGHT*WIDTH/128) (7 at defaults).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 wr_en  input  1  frame-buffer word write strobe.
REQ-007 wr_addr  input  $clog2(NBEATS)  frame-buffer word index.
REQ-008 wr_data  input  128  frame-buffer word; bit i of word w is pixel w*128+i (row-major).
REQ-009 start  input  1  one-cycle request to transmit the buffered frame.
REQ-010 abort  input  1  terminate the current frame.
REQ-011 m_tdata  output  128  AXI-Stream data.
REQ-012 m_tvalid  output  1  AXI-Stream valid.
REQ-013 m_tready  input  1  AXI-Stream ready from the image consumer.
REQ-014 m_tkeep  output  16  AXI-Stream byte enables.
REQ-015 m_tlast  output  1  marks final beat of a frame.
REQ-016 busy  output  1  high while in SEND.
REQ-017 done  output  1  one-cycle pulse after the final beat handshake.
REQ-018 wr_err  output  1  sticky; set when a write is dropped; cleared by rst or start accepted.
REQ-019 frame_count  output  16  number of completed frames.

Function
REQ-020 SHALL implement FSM states IDLE, SEND, FIN; IDLE after reset.
REQ-021 IDLE: start=1 -> SEND; beat index cleared to 0; m_tvalid=1 with beat 0 on the next cycle.
REQ-022 SEND: a beat is transferred only on a cycle where m_tvalid=1 and m_tready=1.
REQ-023 While m_tvalid=1 and m_tready=0, m_tdata, m_tkeep, and m_tlast SHALL hold stable.
REQ-024 m_tvalid SHALL not depend combinationally on m_tready; all stream outputs SHALL be registered.
REQ-025 With m_tready held at 1, beats SHALL issue back-to-back, one per cycle; frame occupies NBEATS consecutive cycles.
REQ-026 m_tdata for beat b = buffer word b; bits at positions >= HEIGHT*WIDTH - b*128 in the final beat SHALL be 0.
REQ-027 m_tkeep = 16'hFFFF for non-final beats; for the final beat, the low ceil(R/8) bits are set, where R = HEIGHT*WIDTH - (NBEATS-1)*128 (16'h0003 at defaults).
REQ-028 m_tlast = 1 only on beat NBEATS-1.
REQ-029 Final beat handshake -> FIN; next cycle m_tvalid=0, done=1 for one cycle, frame_count+1 (16-bit wrap at 0xFFFF->0), -> IDLE.
REQ-030 start while busy or in FIN SHALL be ignored.
REQ-031 wr_en in IDLE SHALL write wr_data to word wr_addr; wr_addr >= NBEATS SHALL be dropped and set wr_err.
REQ-032 wr_en while busy or in FIN SHALL be dropped, leave the buffer unchanged, and set wr_err.
REQ-033 Simultaneous wr_en and start in IDLE: the write SHALL complete and start SHALL be accepted; beat 0 SHALL reflect the newly written data if wr_addr=0.
REQ-034 abort in SEND (any beat, any m_tready): next cycle m_tvalid=0, m_tlast=0, -> IDLE; no done pulse; frame_count unchanged.
REQ-035 abort in IDLE or FIN SHALL have no effect; abort has priority over a same-cycle final handshake (that frame SHALL not be counted).
REQ-036 The buffer SHALL retain its contents after a frame; repeated start SHALL resend an identical frame.

Reset
REQ-037 rst=1 SHALL force IDLE, with m_tvalid, m_tlast, busy, done, and wr_err = 0, m_tdata = 0, m_tkeep = 0, and frame_count = 0, on the next edge, including mid-frame.
REQ-038 Frame-buffer contents SHALL not be cleared by rst.
REQ-039 rst SHALL have priority over start, abort, and wr_en in the same cycle.

Verification
REQ-040 Write words 0..6 = {16{8'h(w+1)}}; start; m_tready=1 -> 7 consecutive beats, beat6 tdata=0x...0707 low 16 bits only, tkeep=16'h0003, tlast=1; done pulses 1 cycle later; frame_count=1.
REQ-041 Same frame, m_tready toggling 1,0,0,1 repeating -> exactly 7 transfers; data, keep, and last stable during stalls; no beat repeated or skipped.
REQ-042 Assert abort during beat 3 with m_tready=0 -> m_tvalid=0 the next cycle, no done, frame_count unchanged; a subsequent start resends from beat 0.
REQ-043 wr_en during SEND to addr 2 -> wr_err=1; beat 2 carries the old data; after start, wr_err=0.
REQ-044 rst asserted at beat 4 -> all outputs 0 the next cycle; after release, start resends the retained buffer intact.
REQ-045 frame_count preloaded to 0xFFFF by sending 65535 frames (or forced) -> the next frame wraps it to 0x0000.
